// File: rtl/cache_bridge_pkg.sv
// Shared request type codes and controller state encoding for the cache/SRAM bridge.
package cache_bridge_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_ISSUE = 2'd1;
  localparam logic [1:0] ST_WR_DRAIN = 2'd2;

  function automatic logic is_line(input logic [2:0] req_type);
    return req_type == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_sram_wbuf.sv
// Single-entry 128-bit write buffer; drains one SRAM word per cycle while drain is high.
module cache_sram_wbuf
  import cache_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [3:0]        ld_strb,
  input  logic [127:0]      ld_data,
  input  logic              drain,
  output logic              empty,
  output logic              last,
  output logic [3:0]        we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata
);

  logic              valid_q;
  logic              line_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        strb_q;
  logic [127:0]      data_q;
  logic [1:0]        cnt_q;
  logic [1:0]        word_sel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      line_q  <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      line_q  <= is_line(ld_type);
      addr_q  <= ld_addr;
      strb_q  <= ld_strb;
      data_q  <= ld_data;
      cnt_q   <= '0;
    end else if (drain && valid_q) begin
      if (last) valid_q <= 1'b0;
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // addr_q holds a word address, so its low two bits select the word within the line.
  always_comb begin
    word_sel = line_q ? cnt_q : addr_q[1:0];
    empty    = ~valid_q;
    last     = ~line_q | (cnt_q == 2'd3);
    we       = line_q ? 4'hf : strb_q;
    addr     = line_q ? {addr_q[ADDR_W-1:2], cnt_q} : addr_q;
    wdata    = data_q[{word_sel, 5'b0} +: 32];
  end

endmodule

// File: rtl/cache_sram_bridge.sv
// Bridges cache read/write requests onto a single-port synchronous SRAM.
// Define CACHE_SRAM_BRIDGE_CNT_EN to add accepted line read/write counters.
module cache_sram_bridge
  import cache_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [2:0]        rd_type,
  input  logic [31:0]       rd_addr,
  output logic              rd_rdy,
  output logic              ret_valid,
  output logic              ret_last,
  output logic [31:0]       ret_data,
  input  logic              wr_req,
  input  logic [2:0]        wr_type,
  input  logic [31:0]       wr_addr,
  input  logic [3:0]        wr_wstrb,
  input  logic [127:0]      wr_data,
  output logic              wr_rdy,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef CACHE_SRAM_BRIDGE_CNT_EN
  ,
  output logic [31:0]       rd_line_cnt,
  output logic [31:0]       wr_line_cnt
`endif
);

  logic [1:0]        state_q, state_d;
  logic              rd_line_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        rd_cnt_q;
  logic              ret_valid_q, ret_last_q;
  logic              rd_accept, wr_accept, rd_last;
  logic              wb_empty, wb_last;
  logic [3:0]        wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_wdata;
  logic              unused_addr;

  assign unused_addr = ^{wr_addr[31:ADDR_W+2], wr_addr[1:0], rd_addr[31:ADDR_W+2], rd_addr[1:0]};

  // Ready outputs are gated by resetn so they drop the instant reset asserts.
  assign wr_rdy    = resetn & (state_q == ST_IDLE) & wb_empty;
  assign rd_rdy    = wr_rdy & ~wr_req;
  assign wr_accept = wr_req & wr_rdy;
  assign rd_accept = rd_req & rd_rdy;
  assign rd_last   = ~rd_line_q | (rd_cnt_q == 2'd3);

  cache_sram_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk     (clk),
    .resetn  (resetn),
    .load    (wr_accept),
    .ld_type (wr_type),
    .ld_addr (wr_addr[ADDR_W+1:2]),
    .ld_strb (wr_wstrb),
    .ld_data (wr_data),
    .drain   (state_q == ST_WR_DRAIN),
    .empty   (wb_empty),
    .last    (wb_last),
    .we      (wb_we),
    .addr    (wb_addr),
    .wdata   (wb_wdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_accept)      state_d = ST_WR_DRAIN;
        else if (rd_accept) state_d = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: if (rd_last) state_d = ST_IDLE;
      ST_WR_DRAIN: if (wb_last) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rd_line_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_valid_q <= (state_q == ST_RD_ISSUE);
      ret_last_q  <= (state_q == ST_RD_ISSUE) & rd_last;
      if (rd_accept) begin
        rd_line_q <= is_line(rd_type);
        rd_addr_q <= rd_addr[ADDR_W+1:2];
        rd_cnt_q  <= '0;
      end else if (state_q == ST_RD_ISSUE) begin
        rd_cnt_q  <= rd_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_RD_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = rd_line_q ? {rd_addr_q[ADDR_W-1:2], rd_cnt_q} : rd_addr_q;
    end else if (state_q == ST_WR_DRAIN) begin
      mem_en    = 1'b1;
      mem_we    = wb_we;
      mem_addr  = wb_addr;
      mem_wdata = wb_wdata;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_valid_q ? mem_rdata : 32'h0;

`ifdef CACHE_SRAM_BRIDGE_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_line_cnt <= '0;
      wr_line_cnt <= '0;
    end else begin
      if (rd_accept && is_line(rd_type)) rd_line_cnt <= rd_line_cnt + 32'd1;
      if (wr_accept && is_line(wr_type)) wr_line_cnt <= wr_line_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_sram_bridge.sv
// Directed self-checking bench for cache_sram_bridge with a one-cycle-latency SRAM model.
module tb_cache_sram_bridge;
  import cache_bridge_pkg::*;

  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              rd_req = 1'b0;
  logic [2:0]        rd_type = TYPE_WORD;
  logic [31:0]       rd_addr = '0;
  logic              rd_rdy;
  logic              ret_valid;
  logic              ret_last;
  logic [31:0]       ret_data;
  logic              wr_req = 1'b0;
  logic [2:0]        wr_type = TYPE_WORD;
  logic [31:0]       wr_addr = '0;
  logic [3:0]        wr_wstrb = '0;
  logic [127:0]      wr_data = '0;
  logic              wr_rdy;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
`ifdef CACHE_SRAM_BRIDGE_CNT_EN
  logic [31:0]       rd_line_cnt;
  logic [31:0]       wr_line_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] sram [0:1023];

  always #5 clk = ~clk;

  cache_sram_bridge #(
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef CACHE_SRAM_BRIDGE_CNT_EN
    ,
    .rd_line_cnt (rd_line_cnt),
    .wr_line_cnt (wr_line_cnt)
`endif
  );

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one read and checks every cycle of the issue/return window.
  task automatic do_read(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] a0,
                         input int n, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp = '{e0, e1, e2, e3};
    @(negedge clk);
    rd_req = 1'b1; rd_type = typ; rd_addr = addr;
    #1 check("rd_rdy", 32'(rd_rdy), 32'd1);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      if (c <= n) begin
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_mem_addr", 32'(mem_addr), a0 + 32'(c - 1));
      end else begin
        check("rd_mem_en_off", 32'(mem_en), 32'd0);
        check("rd_rdy_last_beat", 32'(rd_rdy), 32'd1);
      end
      check("ret_valid", 32'(ret_valid), 32'(c >= 2));
      if (c >= 2) begin
        check("ret_data", ret_data, exp[c-2]);
        check("ret_last", 32'(ret_last), 32'(c == n + 1));
      end
    end
    @(negedge clk);
    #1;
    check("ret_valid_idle", 32'(ret_valid), 32'd0);
    check("ret_last_idle", 32'(ret_last), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
    sram[10'h48C] = 32'hA0A0_0001;
    sram[10'h48D] = 32'hB0B0_0002;
    sram[10'h48E] = 32'hC0C0_0003;
    sram[10'h48F] = 32'hD0D0_0004;
    sram[10'h002] = 32'h2222_3333;
    sram[10'h041] = 32'hAAAA_AAAA;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
    check("rst_wr_rdy", 32'(wr_rdy), 32'd0);
    check("rst_ret_valid", 32'(ret_valid), 32'd0);
    check("rst_ret_last", 32'(ret_last), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_ret_data", ret_data, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    #1 check("idle_wr_rdy", 32'(wr_rdy), 32'd1);

    // Line read of the line at 0x1230 (words 0x48C..0x48F)
    do_read(TYPE_LINE, 32'h0000_1230, 32'h48C, 4,
            32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004);
    // Word read 0x8, half read 0x1236
    do_read(TYPE_WORD, 32'h0000_0008, 32'h002, 1, 32'h2222_3333, 0, 0, 0);
    do_read(TYPE_HALF, 32'h0000_1236, 32'h48D, 1, 32'hB0B0_0002, 0, 0, 0);

    // Line write to 0x40
    @(negedge clk);
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h0000_0040; wr_wstrb = 4'h0;
    wr_data = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    #1;
    check("lw_wr_rdy", 32'(wr_rdy), 32'd1);
    check("lw_rd_rdy", 32'(rd_rdy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      check("lw_mem_en", 32'(mem_en), 32'd1);
      check("lw_mem_we", 32'(mem_we), 32'hf);
      check("lw_mem_addr", 32'(mem_addr), 32'h10 + 32'(k));
      check("lw_mem_wdata", mem_wdata, wr_data[32*k +: 32]);
      check("lw_wr_rdy_busy", 32'(wr_rdy), 32'd0);
    end
    @(negedge clk);
    #1;
    check("lw_mem_en_off", 32'(mem_en), 32'd0);
    check("lw_wr_rdy_done", 32'(wr_rdy), 32'd1);
    check("lw_sram0", sram[10'h010], 32'hD0D0_0000);
    check("lw_sram3", sram[10'h013], 32'hD3D3_0003);

    // Word write 0x106, wstrb 0011
    @(negedge clk);
    wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0106; wr_wstrb = 4'b0011;
    wr_data = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    check("ww_mem_en", 32'(mem_en), 32'd1);
    check("ww_mem_addr", 32'(mem_addr), 32'h41);
    check("ww_mem_we", 32'(mem_we), 32'h3);
    check("ww_mem_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    #1;
    check("ww_mem_en_off", 32'(mem_en), 32'd0);
    check("ww_sram", sram[10'h041], 32'hAAAA_5678);

    // Simultaneous write and read to 0x8: write wins, read sees new data
    @(negedge clk);
    wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0008; wr_wstrb = 4'hf;
    wr_data = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0008;
    #1;
    check("sim_wr_rdy", 32'(wr_rdy), 32'd1);
    check("sim_rd_rdy", 32'(rd_rdy), 32'd0);
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    check("sim_drain_we", 32'(mem_we), 32'hf);
    check("sim_drain_addr", 32'(mem_addr), 32'h2);
    check("sim_rd_rdy_drain", 32'(rd_rdy), 32'd0);
    @(negedge clk);
    #1 check("sim_rd_rdy_after", 32'(rd_rdy), 32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    check("sim_rd_en", 32'(mem_en), 32'd1);
    check("sim_rd_we", 32'(mem_we), 32'd0);
    check("sim_rd_addr", 32'(mem_addr), 32'h2);
    @(negedge clk);
    #1;
    check("sim_ret_valid", 32'(ret_valid), 32'd1);
    check("sim_ret_data", ret_data, 32'hCAFE_F00D);
    check("sim_ret_last", 32'(ret_last), 32'd1);

    // Reset during the second beat of a line read
    @(negedge clk);
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h0000_1230;
    #1 check("rr_rd_rdy", 32'(rd_rdy), 32'd1);
    @(negedge clk);
    rd_req = 1'b0;
    #1 check("rr_first_addr", 32'(mem_addr), 32'h48C);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rr_beat2_valid", 32'(ret_valid), 32'd1);
    check("rr_beat2_data", ret_data, 32'hB0B0_0002);
`ifdef CACHE_SRAM_BRIDGE_CNT_EN
    check("cnt_rd_pre", rd_line_cnt, 32'd2);
    check("cnt_wr_pre", wr_line_cnt, 32'd1);
`endif
    resetn = 1'b0;
    #1;
    check("rr_ret_valid", 32'(ret_valid), 32'd0);
    check("rr_ret_last", 32'(ret_last), 32'd0);
    check("rr_ret_data", ret_data, 32'd0);
    check("rr_mem_en", 32'(mem_en), 32'd0);
    check("rr_rd_rdy", 32'(rd_rdy), 32'd0);
    check("rr_wr_rdy", 32'(wr_rdy), 32'd0);
`ifdef CACHE_SRAM_BRIDGE_CNT_EN
    check("cnt_rd_rst", rd_line_cnt, 32'd0);
    check("cnt_wr_rst", wr_line_cnt, 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_valid", 32'(ret_valid), 32'd0);
      check("post_rst_mem_en", 32'(mem_en), 32'd0);
    end

    // Byte read after reset; beat counter restarts at word 0
    do_read(TYPE_BYTE, 32'h0000_1233, 32'h48C, 1, 32'hA0A0_0001, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
